ofdm_bit_transmitter: RTL
=========================

# ofdm_bit_transmitter

Serial-bit frame transmitter, the sending end of the receiver's bitstream interface. Accepts a start command with payload length, pulls payload bits one at a time through a request handshake, and emits one output bit per clock. The frame is a 96-bit alternating preamble, an 8-bit start delimiter, a 16-bit length field, the payload through a rate-1/2 K=7 convolutional encoder (802.11a generators), and an encoded 6-bit zero tail. Sits between the MAC-side bit source and the serial channel model that feeds `Receiver`.

## Interface
- `PREAMBLE_LEN`, 96: number of alternating preamble bits. Must be even.
- `SFD`, 8'b11010000: start-frame delimiter, sent MSB first.
- Ports (clock and reset first):
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: frame request; sampled only in IDLE.
- `Length` in 16: payload bit count; captured with `Start`.
- `DataIn` in 1: payload bit; sampled on edges where `DataReq`=1.
- `DataReq` out 1: registered; high when `DataIn` is consumed at the next edge.
- `Output` out 1: registered serial bit.
- `OutValid` out 1: registered; high while `Output` carries a frame bit.
- `Busy` out 1: high from the cycle after an accepted `Start` through the last tail bit.
- `Error` out 1: one-cycle pulse on a rejected `Start`.

## Operation
- States: IDLE → PRE → SFD → LEN → DATA → TAIL → IDLE.
- IDLE: `Start`=1 and `Length`≠0 latches `Length`, clears the 6-bit encoder register, and loads the scrambler seed (if compiled in). Next state is PRE. `Start`=1 with `Length`=0 pulses `Error` and stays in IDLE.
- PRE: emits `PREAMBLE_LEN` bits 1,0,1,0,…, starting with 1.
- SFD: emits 8 bits of `SFD`, MSB first.
- LEN: emits the latched `Length`, 16 bits, MSB first.
- DATA: each payload bit u produces two bits, A then B.
  - A = parity of taps g0 = 133 octal (delays 0,2,3,5,6).
  - B = parity of taps g1 = 171 octal (delays 0,1,2,3,6).
  - Delay 0 is u itself. u shifts into the encoder register after B.
- TAIL: six zero bits are encoded the same way (12 output bits), then the block returns to IDLE.
- Frame length = `PREAMBLE_LEN` + 24 + 2·`Length` + 12 cycles.
- Internal counters are 16-bit for payload and 7-bit for preamble/field. No wrap inside a frame: `Length`=65535 is legal.

## Timing
- Reset values: `Output`=0, `OutValid`=0, `DataReq`=0, `Busy`=0, `Error`=0, state=IDLE.
- `Start` sampled at edge N → first preamble bit on `Output`, and `OutValid`=`Busy`=1, from edge N+1.
- `DataReq`=1 exactly in cycles where the next `Output` bit is an A bit. That is the last LEN cycle and every B cycle except that of the final payload bit.
- The A bit of the consumed `DataIn` appears at the same edge that samples it. No stall: the source must present valid data whenever `DataReq`=1.
- After the last tail bit, the next edge gives `OutValid`=`Busy`=0 and `Output`=0. A new `Start` is accepted in that IDLE cycle, giving a minimum 1-cycle gap between frames.
- `Start` while `Busy`: ignored, `Error` pulses one cycle, the frame continues unaffected.
- `Reset` mid-frame: the next edge restores all reset values. The partial frame is abandoned and no tail is sent.

## Configuration
- `TX_SCRAMBLER_EN` defined: payload bits are XORed with an x^7+x^4+1 scrambler before encoding. The seed 7'b1011101 is loaded on `Start`, and the scrambler advances once per payload bit. Tail bits are always unscrambled zeros.
- Undefined: payload bits are encoded directly, and no scrambler logic is synthesized.

## Test plan
- Reset state: hold `Reset` for 3 cycles → all outputs 0. Release with `Start`=0 → outputs remain 0.
- Single bit, scrambler off: `Length`=1, `DataIn`=1.
  - Frame is 134 cycles.
  - Bits 1–96 are 1010….
  - Bits 97–104 are 11010000.
  - Bits 105–120 are 0x0001.
  - Bits 121–134 are 11 01 11 11 00 10 11.
  - `DataReq` is high only in cycle 120.
- All-zero payload: `Length`=8, `DataIn`=0 (scrambler off) → 28 encoded bits, all 0. Total 148 cycles. `DataReq` is high 8 times.
- Errors: `Start` with `Length`=0 → `Error` pulse, `Busy` stays 0. `Start` at cycle 50 of a frame → `Error` pulse, and the frame is bit-identical to an undisturbed run.
- Reset mid-frame: assert `Reset` at payload bit 3 of `Length`=10 → `Output`/`OutValid`/`Busy`=0 next edge. A subsequent `Start` produces a full, correct frame.
- Back-to-back: issue a second `Start` in the IDLE cycle after frame 1 → frame 2 begins with `Output`=1 one edge later. Encoder state is cleared, checked against a reference model.

Source files
------------

// File: rtl/ofdm_bit_transmitter.sv
// ofdm_bit_transmitter: serial frame transmitter.
// Frame = alternating preamble, start delimiter, 16-bit length, payload
// through a rate-1/2 K=7 convolutional encoder (g0=133, g1=171 octal),
// then a six-bit encoded zero tail. One output bit per clock.
// Optional feature: define TX_SCRAMBLER_EN to whiten payload bits with an
// x^7+x^4+1 scrambler before encoding.
module ofdm_bit_transmitter #(
  parameter int         PREAMBLE_LEN = 96,
  parameter logic [7:0] SFD          = 8'b11010000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Length,
  input  logic        DataIn,
  output logic        DataReq,
  output logic        Output,
  output logic        OutValid,
  output logic        Busy,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_TAIL = 3'd5
  } state_t;

  // Tap masks over {delay6..delay1, delay0}; bit i is delay i.
  localparam logic [6:0] G0_MASK  = 7'b1101101;
  localparam logic [6:0] G1_MASK  = 7'b1001111;
  localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_LEN - 1);

  // Encoder output bit: parity of the tapped delays (delay 0 is u itself).
  function automatic logic enc_bit(input logic u, input logic [5:0] sr, input logic [6:0] mask);
    return ^({sr, u} & mask);
  endfunction

  // state_q describes the bit currently presented on Output.
  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;     // bit index inside PRE/SFD/LEN/TAIL
  logic [15:0] len_q, len_d;     // latched payload length
  logic [15:0] rem_q, rem_d;     // payload bits still to be consumed
  logic [5:0]  sr_q, sr_d;       // encoder delays 1..6 (sr[0] = delay 1)
  logic        u_q, u_d;         // payload bit being encoded
  logic        b_q, b_d;         // 1 while Output carries a B bit
  logic        out_q, out_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        din_s;
  logic [5:0]  sr_shift_s;
  logic [6:0]  cnt_inc_s;

`ifdef TX_SCRAMBLER_EN
  logic [6:0] scr_q, scr_d;
  logic       scr_fb_s;
  assign scr_fb_s = scr_q[6] ^ scr_q[3];
  assign din_s    = DataIn ^ scr_fb_s;

  // Scrambler: seeded on an accepted Start, steps once per consumed bit.
  always_comb begin
    scr_d = scr_q;
    if (state_q == S_IDLE && Start && Length != 16'd0) begin
      scr_d = 7'b1011101;
    end else if (req_q) begin
      scr_d = {scr_q[5:0], scr_fb_s};
    end else begin
      scr_d = scr_q;
    end
  end

  // Scrambler register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      scr_q <= 7'd0;
    end else begin
      scr_q <= scr_d;
    end
  end
`else
  assign din_s = DataIn;
`endif

  // Next-state and next-output computation for the whole frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    rem_d      = rem_q;
    sr_d       = sr_q;
    u_d        = u_q;
    b_d        = b_q;
    out_d      = 1'b0;
    req_d      = 1'b0;
    err_d      = Start & (state_q != S_IDLE);
    sr_shift_s = {sr_q[4:0], u_q};
    cnt_inc_s  = cnt_q + 7'd1;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Length != 16'd0) begin
            state_d = S_PRE;
            cnt_d   = 7'd0;
            len_d   = Length;
            sr_d    = 6'd0;
            u_d     = 1'b0;
            b_d     = 1'b0;
            out_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          cnt_d   = 7'd0;
          out_d   = SFD[7];
        end else begin
          cnt_d = cnt_inc_s;
          out_d = ~cnt_inc_s[0];
        end
      end
      S_SFD: begin
        if (cnt_q == 7'd7) begin
          state_d = S_LEN;
          cnt_d   = 7'd0;
          out_d   = len_q[15];
        end else begin
          cnt_d = cnt_inc_s;
          out_d = SFD[3'd7 - cnt_inc_s[2:0]];
        end
      end
      S_LEN: begin
        if (cnt_q == 7'd15) begin
          // DataReq was high this cycle: consume the first payload bit.
          state_d = S_DATA;
          u_d     = din_s;
          b_d     = 1'b0;
          rem_d   = len_q - 16'd1;
          out_d   = enc_bit(din_s, sr_q, G0_MASK);
        end else begin
          cnt_d = cnt_inc_s;
          out_d = len_q[4'd15 - cnt_inc_s[3:0]];
          req_d = (cnt_inc_s == 7'd15);
        end
      end
      S_DATA: begin
        if (!b_q) begin
          b_d   = 1'b1;
          out_d = enc_bit(u_q, sr_q, G1_MASK);
          req_d = (rem_q != 16'd0);
        end else begin
          sr_d = sr_shift_s;
          b_d  = 1'b0;
          if (rem_q != 16'd0) begin
            u_d   = din_s;
            rem_d = rem_q - 16'd1;
            out_d = enc_bit(din_s, sr_shift_s, G0_MASK);
          end else begin
            state_d = S_TAIL;
            cnt_d   = 7'd0;
            u_d     = 1'b0;
            out_d   = enc_bit(1'b0, sr_shift_s, G0_MASK);
          end
        end
      end
      S_TAIL: begin
        if (!b_q) begin
          b_d   = 1'b1;
          out_d = enc_bit(u_q, sr_q, G1_MASK);
        end else begin
          sr_d = sr_shift_s;
          b_d  = 1'b0;
          if (cnt_q == 7'd5) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc_s;
            out_d = enc_bit(1'b0, sr_shift_s, G0_MASK);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d != S_IDLE);
  end

  // Sequencer state and registered outputs; Reset abandons any frame.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      len_q   <= 16'd0;
      rem_q   <= 16'd0;
      sr_q    <= 6'd0;
      u_q     <= 1'b0;
      b_q     <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
      u_q     <= u_d;
      b_q     <= b_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign Output   = out_q;
  assign OutValid = valid_q;
  assign Busy     = busy_q;
  assign DataReq  = req_q;
  assign Error    = err_q;

endmodule
